// File: rtl/cache_controller_pkg.sv
// rtl/cache_controller_pkg.sv - shared FSM state type and cache geometry constants
package cache_controller_pkg;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int OFFSET_W        = 2;
    localparam int INDEX_W         = 12;
    localparam int TAG_W           = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FETCH,
        FILL,
        RESPOND,
        FLUSH
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - read-only cache controller: lookup, block refill, flush, hit/miss stats
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              flush_req,
    output logic [ADDR_W-1:0] lk_addr,
    input  logic              lk_hit,
    input  logic [DATA_W-1:0] lk_rdata,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              cache_clr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(WORDS_PER_BLOCK - 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [OFFSET_W-1:0] beat_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   fill_addr_q;
    logic [DATA_W-1:0]   fill_data_q;
    logic                cpu_ready_q;
    logic                fill_we_q;
    logic                cache_clr_q;
    logic                mem_req_q;
    logic                init_q;

    // init_q forces one invalidate pass right after reset so nothing filled
    // before the reset survives it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            beat_q      <= '0;
            rdata_q     <= '0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
            cpu_ready_q <= 1'b0;
            fill_we_q   <= 1'b0;
            cache_clr_q <= 1'b0;
            mem_req_q   <= 1'b0;
            init_q      <= 1'b1;
        end else begin
            cpu_ready_q <= 1'b0;
            fill_we_q   <= 1'b0;
            cache_clr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (init_q || flush_req) begin
                        init_q      <= 1'b0;
                        cache_clr_q <= 1'b1;
                        state_q     <= FLUSH;
                    end else if (cpu_req) begin
                        req_addr_q <= cpu_addr;
                        state_q    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lk_hit) begin
                        rdata_q     <= lk_rdata;
                        cpu_ready_q <= 1'b1;
                        state_q     <= RESPOND;
                    end else begin
                        mem_req_q <= 1'b1;
                        state_q   <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        beat_q    <= '0;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    if (mem_rvalid) begin
                        fill_we_q   <= 1'b1;
                        fill_addr_q <= {req_addr_q[ADDR_W-1:OFFSET_W], beat_q};
                        fill_data_q <= mem_rdata;
                        if (beat_q == req_addr_q[OFFSET_W-1:0]) begin
                            rdata_q <= mem_rdata;
                        end
                        beat_q <= beat_q + OFFSET_W'(1);
                        if (beat_q == LAST_BEAT) begin
                            cpu_ready_q <= 1'b1;
                            state_q     <= RESPOND;
                        end
                    end
                end
                RESPOND: state_q <= IDLE;
                FLUSH:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   ((state_q == LOOKUP) && lk_hit),
        .count_o (hit_cnt)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   ((state_q == LOOKUP) && !lk_hit),
        .count_o (miss_cnt)
    );

    // req_addr only changes on acceptance, so it doubles as the IDLE lookup address.
    assign lk_addr   = req_addr_q;
    assign mem_addr  = {req_addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = rdata_q;
    assign fill_we   = fill_we_q;
    assign fill_addr = fill_addr_q;
    assign fill_data = fill_data_q;
    assign cache_clr = cache_clr_q;
    assign mem_req   = mem_req_q;

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - scoreboard bench for cache_controller with cache array and memory models
module tb_cache_controller;
    import cache_controller_pkg::*;

    localparam int AW = 15;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int NIDX = 1 << INDEX_W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_req, flush_req, lk_hit, mem_ack, mem_rvalid;
    logic [AW-1:0] cpu_addr, lk_addr, fill_addr, mem_addr;
    logic [DW-1:0] cpu_rdata, lk_rdata, fill_data, mem_rdata;
    logic          cpu_ready, fill_we, cache_clr, mem_req;
    logic [CW-1:0] hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    cache_controller #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .flush_req(flush_req),
        .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_rdata(lk_rdata),
        .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data),
        .cache_clr(cache_clr), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Cache array: direct-mapped, index [11:0], tag [14:12]
    bit            valid_m [NIDX];
    logic [TAG_W-1:0] tag_m [NIDX];
    logic [DW-1:0] data_m [NIDX];

    always @(posedge clk) begin
        if (cache_clr) begin
            for (int i = 0; i < NIDX; i++) valid_m[i] <= 1'b0;
        end else if (fill_we) begin
            valid_m[fill_addr[INDEX_W-1:0]] <= 1'b1;
            tag_m[fill_addr[INDEX_W-1:0]]   <= fill_addr[AW-1:INDEX_W];
            data_m[fill_addr[INDEX_W-1:0]]  <= fill_data;
        end
    end

    assign lk_hit   = valid_m[lk_addr[INDEX_W-1:0]] && (tag_m[lk_addr[INDEX_W-1:0]] == lk_addr[AW-1:INDEX_W]);
    assign lk_rdata = data_m[lk_addr[INDEX_W-1:0]];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } fill_t;

    logic [DW-1:0] rsp_q[$];
    fill_t         fill_q[$];
    int            rsp_seen  = 0;
    int            fill_seen = 0;

    // Monitor: pops expectations whenever the DUT presents a response or a fill
    always @(negedge clk) begin
        fill_t f;
        if (rst && cpu_ready) begin
            rsp_seen++;
            if (rsp_q.size() == 0) check("unexpected_cpu_ready", 32'd1, 32'd0);
            else check("cpu_rdata", cpu_rdata, rsp_q.pop_front());
        end
        if (rst && fill_we) begin
            fill_seen++;
            if (fill_q.size() == 0) begin
                check("unexpected_fill_we", 32'd1, 32'd0);
            end else begin
                f = fill_q.pop_front();
                check("fill_addr", 32'(fill_addr), 32'(f.a));
                check("fill_data", fill_data, f.d);
            end
        end
    end

    // Memory model: programmable ack delay and per-beat gaps; stray beat alongside ack
    int            ack_delay = 0;
    int            gap[4]    = '{0, 0, 0, 0};
    logic [DW-1:0] mem_base  = '0;
    logic [AW-1:0] exp_mem_addr = '0;
    int            mem_txn   = 0;
    bit            mem_busy  = 1'b0;

    initial begin
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst && mem_req) begin
                mem_busy = 1'b1;
                mem_txn++;
                check("mem_addr", 32'(mem_addr), 32'(exp_mem_addr));
                for (int i = 0; i < ack_delay; i++) begin
                    @(negedge clk);
                    check("mem_req_held", 32'(mem_req), 32'd1);
                end
                mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
                @(negedge clk);
                mem_ack = 1'b0; mem_rvalid = 1'b0;
                check("mem_req_drop", 32'(mem_req), 32'd0);
                for (int b = 0; b < 4; b++) begin
                    repeat (gap[b]) @(negedge clk);
                    mem_rvalid = 1'b1; mem_rdata = mem_base + 32'(b);
                    @(negedge clk);
                    mem_rvalid = 1'b0;
                end
                mem_busy = 1'b0;
            end
        end
    end

    int exp_hit  = 0;
    int exp_miss = 0;

    function automatic int sat(input int v);
        return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
    endfunction

    // Called at a negedge with the DUT idle; acceptance happens at the next posedge
    task automatic do_read(input logic [AW-1:0] addr, input bit hit, input logic [DW-1:0] exp_d,
                           input logic [DW-1:0] base);
        int lat;
        int txn0;
        fill_t f;
        txn0 = mem_txn;
        rsp_q.push_back(exp_d);
        if (hit) begin
            exp_hit = sat(exp_hit + 1);
        end else begin
            exp_miss     = sat(exp_miss + 1);
            mem_base     = base;
            exp_mem_addr = {addr[AW-1:2], 2'b00};
            for (int b = 0; b < 4; b++) begin
                f.a = {addr[AW-1:2], 2'(b)};
                f.d = base + 32'(b);
                fill_q.push_back(f);
            end
        end
        cpu_req  = 1'b1;
        cpu_addr = addr;
        @(negedge clk);
        cpu_req  = 1'b0;
        cpu_addr = ~addr;
        check("lk_hit", 32'(lk_hit), 32'(hit));
        lat = 1;
        while (!cpu_ready && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("cpu_ready_seen", 32'(cpu_ready), 32'd1);
        if (hit) begin
            check("hit_latency", 32'(lat), 32'd2);
            check("hit_no_mem_req", 32'(mem_txn), 32'(txn0));
        end
        check("hit_cnt", 32'(hit_cnt), 32'(exp_hit));
        check("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
        @(negedge clk);
        check("cpu_ready_pulse", 32'(cpu_ready), 32'd0);
    endtask

    task automatic check_all_zero();
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_fill_we", 32'(fill_we), 32'd0);
        check("rst_cache_clr", 32'(cache_clr), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_fill_addr", 32'(fill_addr), 32'd0);
        check("rst_fill_data", fill_data, 32'd0);
        check("rst_lk_addr", 32'(lk_addr), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_cache_clr", 32'(cache_clr), 32'd1);
        @(negedge clk);
        check("post_rst_cache_clr_end", 32'(cache_clr), 32'd0);
    endtask

    initial begin
        int t;
        int r0;
        int f0;
        cpu_req = 1'b0; cpu_addr = '0; flush_req = 1'b0;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero();
        release_reset();

        // Cold miss, then hit on the refilled block, then conflicting tag
        do_read(15'h1235, 1'b0, 32'hA1, 32'hA0);
        do_read(15'h1236, 1'b1, 32'hA2, 32'h0);
        do_read(15'h5234, 1'b0, 32'hB0, 32'hB0);

        // Slow ack and gapped beats
        ack_delay = 5;
        gap = '{0, 2, 0, 3};
        r0 = rsp_seen;
        do_read(15'h2ABE, 1'b0, 32'hC2, 32'hC0);
        repeat (3) @(negedge clk);
        check("single_response", 32'(rsp_seen - r0), 32'd1);
        ack_delay = 0;
        gap = '{0, 0, 0, 0};

        // Reset after the second fill beat abandons the refill
        ack_delay = 1;
        gap = '{1, 1, 1, 1};
        mem_base = 32'hD0;
        exp_mem_addr = 15'h0774;
        fill_q.push_back('{a: 15'h0774, d: 32'hD0});
        fill_q.push_back('{a: 15'h0775, d: 32'hD1});
        f0 = fill_seen;
        cpu_req = 1'b1; cpu_addr = 15'h0777;
        @(negedge clk);
        cpu_req = 1'b0;
        t = 0;
        while (fill_seen < f0 + 2 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("two_beats_before_reset", 32'(fill_seen - f0), 32'd2);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero();
        exp_hit = 0;
        exp_miss = 0;
        release_reset();
        t = 0;
        while (mem_busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("mem_model_idle", 32'(mem_busy), 32'd0);
        ack_delay = 0;
        gap = '{0, 0, 0, 0};
        do_read(15'h0777, 1'b0, 32'hD3, 32'hD0);

        // Drive the miss counter into saturation
        for (int i = 0; i < 16; i++) begin
            do_read({3'(i % 8), 12'h100}, 1'b0, 32'h1000 + 32'(16 * i), 32'h1000 + 32'(16 * i));
        end
        check("miss_cnt_saturated", 32'(miss_cnt), 32'hF);

        // Flush and request together: flush first, then the held request misses
        flush_req = 1'b1;
        cpu_req = 1'b1;
        cpu_addr = 15'h7100;
        @(negedge clk);
        check("flush_cache_clr", 32'(cache_clr), 32'd1);
        flush_req = 1'b0;
        @(negedge clk);
        check("flush_cache_clr_end", 32'(cache_clr), 32'd0);
        do_read(15'h7100, 1'b0, 32'hE0, 32'hE0);
        check("miss_cnt_stays_max", 32'(miss_cnt), 32'hF);
        do_read(15'h7103, 1'b1, 32'hE3, 32'h0);

        repeat (3) @(negedge clk);
        check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        check("fill_queue_drained", 32'(fill_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning word address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data word width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning hit/miss counter width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-low.
REQ-006 SHALL have port cpu_req, input, 1, meaning CPU read request.
REQ-007 SHALL have port cpu_addr, input, ADDR_W, meaning CPU word address.
REQ-008 SHALL have port cpu_ready, output, 1, meaning one-cycle completion pulse.
REQ-009 SHALL have port cpu_rdata, output, DATA_W, meaning read data, valid while cpu_ready=1.
REQ-010 SHALL have port flush_req, input, 1, meaning request to invalidate the whole cache.
REQ-011 SHALL have port lk_addr, output, ADDR_W, meaning lookup address to the cache array.
REQ-012 SHALL have port lk_hit, input, 1, meaning tag match and valid for lk_addr, combinational.
REQ-013 SHALL have port lk_rdata, input, DATA_W, meaning cached word at lk_addr.
REQ-014 SHALL have port fill_we, output, 1, meaning write one word into the cache and set its valid bit.
REQ-015 SHALL have port fill_addr, output, ADDR_W, meaning full address of the filled word; the cache takes the index from [11:0] and the tag from [14:12].
REQ-016 SHALL have port fill_data, output, DATA_W, meaning word to write.
REQ-017 SHALL have port cache_clr, output, 1, meaning one-cycle invalidate-all pulse.
REQ-018 SHALL have port mem_req, output, 1, meaning block-fetch request to main memory.
REQ-019 SHALL have port mem_addr, output, ADDR_W, meaning block-aligned fetch address, with bits [1:0]=0.
REQ-020 SHALL have port mem_ack, input, 1, meaning memory accepted mem_req.
REQ-021 SHALL have port mem_rvalid, input, 1, meaning one returned data beat.
REQ-022 SHALL have port mem_rdata, input, DATA_W, meaning beat data.
REQ-023 SHALL have ports hit_cnt and miss_cnt, output, CNT_W each, meaning statistics counters.

Function
REQ-024 SHALL implement the FSM states IDLE, LOOKUP, FETCH, FILL, RESPOND, and FLUSH.
REQ-025 In IDLE, flush_req SHALL have priority over cpu_req and SHALL cause a transition to FLUSH.
REQ-026 In IDLE, cpu_req SHALL latch cpu_addr into req_addr and cause a transition to LOOKUP.
REQ-027 FLUSH SHALL assert cache_clr for exactly 1 cycle and then return to IDLE.
REQ-028 lk_addr SHALL equal req_addr in every state except IDLE.
REQ-029 In LOOKUP with lk_hit=1, the block SHALL register lk_rdata, increment hit_cnt, and go to RESPOND; hit latency is 2 cycles from the acceptance edge to the cpu_ready pulse.
REQ-030 In LOOKUP with lk_hit=0, the block SHALL increment miss_cnt and go to FETCH.
REQ-031 In FETCH, mem_req SHALL be 1 and mem_addr SHALL be {req_addr[14:2],2'b00}, both held until the cycle mem_ack=1 is sampled, after which the FSM goes to FILL.
REQ-032 FILL SHALL use a 2-bit beat counter starting at 0; each mem_rvalid beat SHALL pulse fill_we with fill_addr={req_addr[14:2],beat} and fill_data=mem_rdata.
REQ-033 The beat whose index equals req_addr[1:0] SHALL be captured as the response data.
REQ-034 After beat 3, the FSM SHALL go to RESPOND.
REQ-035 mem_rvalid SHALL be ignored outside FILL; this includes any beat in the same cycle as mem_ack.
REQ-036 Cycles without a beat SHALL NOT advance the beat counter.
REQ-037 RESPOND SHALL assert cpu_ready for 1 cycle with cpu_rdata valid, then return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-038 Changes on cpu_req or cpu_addr after acceptance SHALL be ignored.
REQ-039 Counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-040 flush_req outside IDLE SHALL be ignored; the requester holds it until cache_clr is seen.
REQ-041 Outputs fill_we, cache_clr, mem_req, and cpu_ready SHALL be driven from state and registers only, with no combinational path from any input.

Reset
REQ-042 When rst=0 at a clock edge, the FSM SHALL enter IDLE.
REQ-043 Reset SHALL clear the counters, req_addr, and the beat counter, and SHALL drive cpu_rdata=0, cpu_ready=0, mem_req=0, fill_we=0, and cache_clr=0.
REQ-044 The first cycle after reset release SHALL assert cache_clr for 1 cycle.
REQ-045 Reset during FILL SHALL abandon the fetch; words already filled remain valid but are cleared by the REQ-044 pulse.

Structure
REQ-046 A shared package SHALL hold the FSM state enum and the constants WORDS_PER_BLOCK=4, OFFSET_W=2, INDEX_W=12, and TAG_W=3.
REQ-047 There SHALL be one sub-module, sat_counter, instantiated twice for hit_cnt and miss_cnt.

Verification
REQ-048 After reset, the bench SHALL see cache_clr=1 for 1 cycle; cpu_req addr 0x1235 with memory returning 0xA0..0xA3 SHALL produce fill_addr 0x1234..0x1237, cpu_rdata=0xA1, and miss_cnt=1.
REQ-049 Repeating a read of 0x1236 SHALL produce lk_hit=1, cpu_ready exactly 2 cycles after acceptance, cpu_rdata=0xA2, hit_cnt=1, and no mem_req.
REQ-050 A read of 0x5234 (same index, different tag) SHALL cause a miss, mem_addr=0x5234, and 4 fill writes.
REQ-051 mem_ack delayed 5 cycles with rvalid gaps of 0, 2, 0, and 3 cycles SHALL keep mem_req held, fill exactly 4 beats in order, and respond once.
REQ-052 rst=0 asserted after the second beat SHALL drive all outputs to 0 on the next edge, return to IDLE, assert cache_clr after release, and cause the next request to the same block to miss.
REQ-053 flush_req in the same cycle as cpu_req SHALL assert cache_clr first; the held cpu_req SHALL then be accepted and miss; miss_cnt preset to 0xFFFF via long stimulus SHALL stay at 0xFFFF.
